// File: rtl/lr_pkg.sv
// Shared definitions for the linear-regression estimator/predictor pair:
// default word format, predictor FSM encoding and saturation limits.
package lr_pkg;

    localparam int LR_DATA_WIDTH = 32;
    localparam int LR_FRAC_BITS  = 16;

    // Predictor control states.
    typedef enum logic [1:0] {
        NO_MODEL = 2'd0,
        IDLE     = 2'd1,
        IN_FRAME = 2'd2,
        DRAIN    = 2'd3
    } lr_state_e;

    // Clip limits for the default word width.
    localparam logic [LR_DATA_WIDTH-1:0] LR_SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [LR_DATA_WIDTH-1:0] LR_SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/lr_mac_sat.sv
// Three-stage z = theta0 + ((theta1 * x) >>> FRAC_BITS) with saturation.
// Every stage advances only when i_en is high; the theta pair travels with x.
module lr_mac_sat
    import lr_pkg::*;
#(
    parameter int DATA_WIDTH = LR_DATA_WIDTH,
    parameter int FRAC_BITS  = LR_FRAC_BITS
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_en,
    input  logic                  i_vld,
    input  logic                  i_last,
    input  logic [DATA_WIDTH-1:0] i_x,
    input  logic [DATA_WIDTH-1:0] i_theta0,
    input  logic [DATA_WIDTH-1:0] i_theta1,
    output logic                  o_vld,
    output logic                  o_last,
    output logic                  o_sat,
    output logic [DATA_WIDTH-1:0] o_z,
    output logic                  o_busy
);

    localparam int W  = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic signed [PW:0] SUM_MAX = {{(W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [PW:0] SUM_MIN = {{(W+2){1'b1}}, {(W-1){1'b0}}};

    logic          s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    logic [W-1:0]  s1_x_q, s1_x_d, s1_t0_q, s1_t0_d, s1_t1_q, s1_t1_d;
    logic          s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
    logic [PW-1:0] s2_scaled_q, s2_scaled_d;
    logic [W-1:0]  s2_t0_q, s2_t0_d;
    logic          out_vld_q, out_vld_d, out_last_q, out_last_d, out_sat_q, out_sat_d;
    logic [W-1:0]  out_z_q, out_z_d;

    logic signed [PW-1:0] t1_ext, x_ext, prod, scaled;
    logic signed [PW:0]   sum;
    logic [W-1:0]         z_clip;
    logic                 sat_clip;

    // Datapath arithmetic: full-width product, shift, widened add, clip.
    always_comb begin
        t1_ext   = {{W{s1_t1_q[W-1]}}, s1_t1_q};
        x_ext    = {{W{s1_x_q[W-1]}}, s1_x_q};
        prod     = t1_ext * x_ext;
        scaled   = prod >>> FRAC_BITS;
        sum      = {s2_scaled_q[PW-1], s2_scaled_q} + {{(W+1){s2_t0_q[W-1]}}, s2_t0_q};
        z_clip   = sum[W-1:0];
        sat_clip = 1'b0;
        if (sum > SUM_MAX) begin
            z_clip   = {1'b0, {(W-1){1'b1}}};
            sat_clip = 1'b1;
        end else if (sum < SUM_MIN) begin
            z_clip   = {1'b1, {(W-1){1'b0}}};
            sat_clip = 1'b1;
        end
    end

    // Next-state for all stages: advance together on enable, otherwise hold.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        s1_vld_d = s1_vld_q;   s1_last_d = s1_last_q;  s1_x_d = s1_x_q;
        s1_t0_d  = s1_t0_q;    s1_t1_d   = s1_t1_q;
        s2_vld_d = s2_vld_q;   s2_last_d = s2_last_q;  s2_scaled_d = s2_scaled_q;
        s2_t0_d  = s2_t0_q;
        out_vld_d = out_vld_q; out_last_d = out_last_q;
        out_sat_d = out_sat_q; out_z_d    = out_z_q;
        if (i_en) begin
            s1_vld_d    = i_vld;     s1_last_d = i_last;    s1_x_d = i_x;
            s1_t0_d     = i_theta0;  s1_t1_d   = i_theta1;
            s2_vld_d    = s1_vld_q;  s2_last_d = s1_last_q;
            s2_scaled_d = scaled;    s2_t0_d   = s1_t0_q;
            out_vld_d   = s2_vld_q;  out_last_d = s2_vld_q & s2_last_q;
            out_sat_d   = s2_vld_q & sat_clip;
            out_z_d     = z_clip;
        end
    end

    // Stage registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            // NOTE: data stages are reset too, so the outputs read exactly 0 out of reset.
            s1_vld_q <= 1'b0;  s1_last_q <= 1'b0;  s1_x_q <= '0;  s1_t0_q <= '0;  s1_t1_q <= '0;
            s2_vld_q <= 1'b0;  s2_last_q <= 1'b0;  s2_scaled_q <= '0;  s2_t0_q <= '0;
            out_vld_q <= 1'b0; out_last_q <= 1'b0; out_sat_q <= 1'b0;  out_z_q <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples the pre-edge value of the one before.
            s1_vld_q <= s1_vld_d;  s1_last_q <= s1_last_d;  s1_x_q <= s1_x_d;
            s1_t0_q  <= s1_t0_d;   s1_t1_q   <= s1_t1_d;
            s2_vld_q <= s2_vld_d;  s2_last_q <= s2_last_d;  s2_scaled_q <= s2_scaled_d;
            s2_t0_q  <= s2_t0_d;
            out_vld_q <= out_vld_d; out_last_q <= out_last_d;
            out_sat_q <= out_sat_d; out_z_q    <= out_z_d;
        end
    end

    assign o_vld  = out_vld_q;
    assign o_last = out_last_q;
    assign o_sat  = out_sat_q;
    assign o_z    = out_z_q;
    assign o_busy = s1_vld_q | s2_vld_q | out_vld_q;

endmodule

// File: rtl/linear_regression_predictor.sv
// Applies the most recent fitted (theta0, theta1) to framed x samples.
// Theta strobes land in a shadow pair; the active pair is only swapped
// between frames with the pipeline empty, so a frame never mixes models.
module linear_regression_predictor
    import lr_pkg::*;
#(
    parameter int DATA_WIDTH = LR_DATA_WIDTH,
    parameter int FRAC_BITS  = LR_FRAC_BITS
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_theta0_in,
    input  logic [DATA_WIDTH-1:0] i_theta1_in,
    input  logic                  i_theta_vld,
    input  logic [DATA_WIDTH-1:0] i_samples_x_in,
    input  logic                  i_samples_x_vld,
    input  logic                  i_samples_x_last,
    output logic                  o_samples_x_rdy,
    output logic [DATA_WIDTH-1:0] o_z_hat_out,
    output logic                  o_z_hat_vld,
    output logic                  o_z_hat_last,
    output logic                  o_z_hat_sat,
    input  logic                  i_z_hat_rdy,
    output logic                  o_model_loaded
);

    lr_state_e             state_q, state_d;
    logic                  pending_q, pending_d;
    logic [DATA_WIDTH-1:0] theta0_s_q, theta0_s_d, theta1_s_q, theta1_s_d;
    logic [DATA_WIDTH-1:0] theta0_a_q, theta0_a_d, theta1_a_q, theta1_a_d;
    logic                  en, accept, pipe_busy, load_active;

    // Handshake: stall everything while a prediction waits downstream.
    // A pending model in IDLE blocks new frames so the swap happens first.
    always_comb begin
        en = !(o_z_hat_vld && !i_z_hat_rdy);
        unique case (state_q)
            IDLE:     o_samples_x_rdy = en && !pending_q;
            IN_FRAME: o_samples_x_rdy = en;
            default:  o_samples_x_rdy = 1'b0;
        endcase
        accept = i_samples_x_vld && o_samples_x_rdy;
    end

    // FSM next state and shadow/active model bookkeeping.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        theta0_s_d  = theta0_s_q;
        theta1_s_d  = theta1_s_q;
        theta0_a_d  = theta0_a_q;
        theta1_a_d  = theta1_a_q;
        load_active = 1'b0;
        unique case (state_q)
            NO_MODEL: begin
                if (pending_q) begin
                    load_active = 1'b1;
                    state_d     = IDLE;
                end
            end
            IDLE: begin
                if (pending_q) begin
                    if (!pipe_busy) load_active = 1'b1;
                    else            state_d     = DRAIN;
                end else if (accept && !i_samples_x_last) begin
                    state_d = IN_FRAME;
                end
            end
            IN_FRAME: begin
                if (accept && i_samples_x_last) state_d = pending_q ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (!pipe_busy) begin
                    load_active = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = NO_MODEL;
        endcase
        if (load_active) begin
            theta0_a_d = theta0_s_q;
            theta1_a_d = theta1_s_q;
            pending_d  = 1'b0;
        end
        // A strobe on the copy edge re-arms pending for the next swap.
        if (i_theta_vld) begin
            theta0_s_d = i_theta0_in;
            theta1_s_d = i_theta1_in;
            pending_d  = 1'b1;
        end
    end

    // Control and model registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= NO_MODEL;
            pending_q  <= 1'b0;
            theta0_s_q <= '0;
            theta1_s_q <= '0;
            theta0_a_q <= '0;
            theta1_a_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            theta0_s_q <= theta0_s_d;
            theta1_s_q <= theta1_s_d;
            theta0_a_q <= theta0_a_d;
            theta1_a_q <= theta1_a_d;
        end
    end

    assign o_model_loaded = (state_q != NO_MODEL);

    lr_mac_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_mac (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_en      (en),
        .i_vld     (accept),
        .i_last    (i_samples_x_last),
        .i_x       (i_samples_x_in),
        .i_theta0  (theta0_a_q),
        .i_theta1  (theta1_a_q),
        .o_vld     (o_z_hat_vld),
        .o_last    (o_z_hat_last),
        .o_sat     (o_z_hat_sat),
        .o_z       (o_z_hat_out),
        .o_busy    (pipe_busy)
    );

endmodule
